// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// alu_issue_ctrl: issues one ALU command at a time from an 8x32 register file,
// waits out the ALU's registered latency, then writes back the result and the APSR.
module alu_issue_ctrl #(
  parameter int NREGS = 8,
  parameter int IMM_W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [4:0]                 cmd_op,
  input  logic [$clog2(NREGS)-1:0]   cmd_rd,
  input  logic [$clog2(NREGS)-1:0]   cmd_rn,
  input  logic [$clog2(NREGS)-1:0]   cmd_rm,
  input  logic                       cmd_use_imm,
  input  logic [IMM_W-1:0]           cmd_imm,
  output logic [4:0]                 alu_instruction,
  output logic [31:0]                alu_num1,
  output logic [31:0]                alu_num2,
  input  logic [31:0]                alu_result,
  input  logic [3:0]                 alu_flags,
  output logic                       done,
  output logic [31:0]                done_result,
  output logic [3:0]                 apsr,
  output logic                       err_illegal,
  input  logic                       wr_en,
  input  logic [$clog2(NREGS)-1:0]   wr_addr,
  input  logic [31:0]                wr_data,
  input  logic [$clog2(NREGS)-1:0]   dbg_addr,
  output logic [31:0]                dbg_data
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_CAPTURE = 2'd2
  } state_t;

  localparam logic [4:0] OP_SUB = 5'd8;
  localparam logic [4:0] OP_CMP = 5'd18;

  state_t                     state_q;
  logic [NREGS-1:0][31:0]     regs_q;
  logic [3:0]                 apsr_q;
  logic [4:0]                 op_q;
  logic [$clog2(NREGS)-1:0]   rd_q;
  logic [4:0]                 instr_q;
  logic [31:0]                num1_q;
  logic [31:0]                num2_q;
  logic                       done_q;
  logic                       err_q;
  logic [31:0]                done_result_q;

  logic                       op_legal_d;
  logic                       op_is_ext_d;
  logic [31:0]                imm_ext_d;

  assign op_legal_d  = (cmd_op != 5'd0) && (cmd_op <= OP_CMP);
  assign op_is_ext_d = (op_q >= 5'd14) && (op_q <= 5'd17);
  assign imm_ext_d   = {{(32-IMM_W){1'b0}}, cmd_imm};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      regs_q        <= '0;
      apsr_q        <= '0;
      op_q          <= '0;
      rd_q          <= '0;
      instr_q       <= '0;
      num1_q        <= '0;
      num2_q        <= '0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      done_result_q <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      // External load first so a same-edge ALU writeback below overrides it.
      if (wr_en) regs_q[wr_addr] <= wr_data;

      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            if (op_legal_d) begin
              num1_q  <= regs_q[cmd_rn];
              num2_q  <= cmd_use_imm ? imm_ext_d : regs_q[cmd_rm];
              instr_q <= (cmd_op == OP_CMP) ? OP_SUB : cmd_op;
              op_q    <= cmd_op;
              rd_q    <= cmd_rd;
              state_q <= S_ISSUE;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        S_ISSUE: state_q <= S_CAPTURE;
        S_CAPTURE: begin
          done_result_q <= alu_result;
          done_q        <= 1'b1;
          if (op_q != OP_CMP) regs_q[rd_q] <= alu_result;
          if (!op_is_ext_d)   apsr_q       <= alu_flags;
          instr_q <= 5'd0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready       = (state_q == S_IDLE);
  assign alu_instruction = instr_q;
  assign alu_num1        = num1_q;
  assign alu_num2        = num2_q;
  assign done            = done_q;
  assign done_result     = done_result_q;
  assign apsr            = apsr_q;
  assign err_illegal     = err_q;
  assign dbg_data        = regs_q[dbg_addr];

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
`default_nettype none
// tb_alu_issue_ctrl: directed + randomized checks of alu_issue_ctrl against a
// register-file/APSR reference model, with a behavioural one-cycle ALU attached.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_use_imm;
  logic [4:0]  cmd_op;
  logic [2:0]  cmd_rd, cmd_rn, cmd_rm;
  logic [7:0]  cmd_imm;
  logic [4:0]  alu_instruction;
  logic [31:0] alu_num1, alu_num2, alu_result;
  logic [3:0]  alu_flags;
  logic        done, err_illegal, wr_en;
  logic [31:0] done_result, wr_data, dbg_data;
  logic [3:0]  apsr;
  logic [2:0]  wr_addr, dbg_addr;

  int errors = 0;
  int checks = 0;

  logic [31:0] m_regs [8];
  logic [3:0]  m_apsr;

  alu_issue_ctrl #(.NREGS(8), .IMM_W(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_rd(cmd_rd), .cmd_rn(cmd_rn), .cmd_rm(cmd_rm),
    .cmd_use_imm(cmd_use_imm), .cmd_imm(cmd_imm),
    .alu_instruction(alu_instruction), .alu_num1(alu_num1), .alu_num2(alu_num2),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .done(done), .done_result(done_result), .apsr(apsr), .err_illegal(err_illegal),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  // ALU stand-in: returns {V,C,Z,N, result}. Extends report C=V=1 so an
  // unwanted APSR update would be visible.
  function automatic logic [35:0] alu_f(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] w;
    logic [31:0] r;
    logic        c, v;
    c = 1'b0; v = 1'b0; w = '0;
    case (op)
      5'd1:  r = a & b;
      5'd6:  begin w = {1'b0, a} + {1'b0, b}; r = w[31:0]; c = w[32];
                   v = (a[31] == b[31]) && (r[31] != a[31]); end
      5'd8:  begin r = a - b; c = (a >= b); v = (a[31] != b[31]) && (r[31] != a[31]); end
      5'd14: begin r = {24'h0, a[7:0]};  c = 1'b1; v = 1'b1; end
      5'd15: begin r = {16'h0, a[15:0]}; c = 1'b1; v = 1'b1; end
      5'd16: begin r = {{24{a[7]}}, a[7:0]};   c = 1'b1; v = 1'b1; end
      5'd17: begin r = {{16{a[15]}}, a[15:0]}; c = 1'b1; v = 1'b1; end
      default: begin r = a ^ (b + {27'h0, op}); c = r[3]; v = r[7]; end
    endcase
    return {v, c, (r == 32'h0), r[31], r};
  endfunction

  always_ff @(posedge clk) {alu_flags, alu_result} <= alu_f(alu_instruction, alu_num1, alu_num2);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_regs();
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i);
      #1;
      check($sformatf("R%0d", i), dbg_data, m_regs[i]);
    end
    check("apsr", {28'h0, apsr}, {28'h0, m_apsr});
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
    m_regs[a] = d;
  endtask

  // Runs one command from IDLE; wph selects an external write in cycle 1 or 2.
  task automatic run_op(input logic [4:0] op, input logic [2:0] rd, input logic [2:0] rn,
                        input logic [2:0] rm, input logic ui, input logic [7:0] imm,
                        input int wph, input logic [2:0] wa, input logic [31:0] wd);
    logic        legal;
    logic [31:0] n1, n2, res;
    logic [3:0]  fl;
    logic [4:0]  ins;
    legal = (op >= 5'd1) && (op <= 5'd18);
    n1  = m_regs[rn];
    n2  = ui ? {24'h0, imm} : m_regs[rm];
    ins = (op == 5'd18) ? 5'd8 : op;
    {fl, res} = alu_f(ins, n1, n2);

    check("ready_idle", {31'h0, cmd_ready}, 32'h1);
    cmd_valid = 1'b1; cmd_op = op; cmd_rd = rd; cmd_rn = rn; cmd_rm = rm;
    cmd_use_imm = ui; cmd_imm = imm;
    tick();
    cmd_valid = 1'b0;

    if (!legal) begin
      check("err_pulse", {31'h0, err_illegal}, 32'h1);
      check("ill_no_done", {31'h0, done}, 32'h0);
      check("ill_instr", {27'h0, alu_instruction}, 32'h0);
      check("ill_ready", {31'h0, cmd_ready}, 32'h1);
      tick();
      check("err_clear", {31'h0, err_illegal}, 32'h0);
      check("ill_no_done2", {31'h0, done}, 32'h0);
      check_regs();
      return;
    end

    check("issue_instr", {27'h0, alu_instruction}, {27'h0, ins});
    check("issue_num1", alu_num1, n1);
    check("issue_num2", alu_num2, n2);
    check("issue_busy", {31'h0, cmd_ready}, 32'h0);
    if (wph == 1) begin wr_en = 1'b1; wr_addr = wa; wr_data = wd; end
    tick();
    wr_en = 1'b0;
    if (wph == 2) begin wr_en = 1'b1; wr_addr = wa; wr_data = wd; end
    check("capt_no_done", {31'h0, done}, 32'h0);
    check("capt_instr_held", {27'h0, alu_instruction}, {27'h0, ins});
    tick();
    wr_en = 1'b0;

    if (wph != 0) m_regs[wa] = wd;
    if (op != 5'd18) m_regs[rd] = res;
    if (!(op >= 5'd14 && op <= 5'd17)) m_apsr = fl;

    check("done_pulse", {31'h0, done}, 32'h1);
    check("done_result", done_result, res);
    check("idle_instr", {27'h0, alu_instruction}, 32'h0);
    check("apsr_upd", {28'h0, apsr}, {28'h0, m_apsr});
    tick();
    check("done_single", {31'h0, done}, 32'h0);
    check_regs();
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_rd = '0; cmd_rn = '0; cmd_rm = '0;
    cmd_use_imm = 1'b0; cmd_imm = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; dbg_addr = '0;
    for (int i = 0; i < 8; i++) m_regs[i] = 32'h0;
    m_apsr = 4'h0;

    #3;
    check("rst_ready", {31'h0, cmd_ready}, 32'h1);
    check("rst_instr", {27'h0, alu_instruction}, 32'h0);
    check("rst_num1", alu_num1, 32'h0);
    check("rst_num2", alu_num2, 32'h0);
    check("rst_done", {31'h0, done}, 32'h0);
    check("rst_err", {31'h0, err_illegal}, 32'h0);
    check("rst_done_result", done_result, 32'h0);
    check_regs();
    rst = 1'b0;
    tick();

    // Directed scenarios
    wr_reg(3'd0, 32'hFFFF_FFFF);
    wr_reg(3'd1, 32'h0000_0001);
    run_op(5'd6, 3'd2, 3'd0, 3'd1, 1'b0, 8'h00, 0, 3'd0, 32'h0);
    check("adds_apsr", {28'h0, apsr}, 32'h6);
    wr_reg(3'd3, 32'h0000_0055);
    run_op(5'd18, 3'd7, 3'd3, 3'd3, 1'b0, 8'h00, 0, 3'd0, 32'h0);
    check("cmp_apsr", {28'h0, apsr}, 32'h6);
    wr_reg(3'd5, 32'h1234_56F0);
    run_op(5'd14, 3'd4, 3'd5, 3'd0, 1'b0, 8'h00, 0, 3'd0, 32'h0);
    check("uxtb_r4", m_regs[4], 32'h0000_00F0);
    check("uxtb_apsr", {28'h0, apsr}, 32'h6);
    run_op(5'd1, 3'd6, 3'd0, 3'd0, 1'b1, 8'h0F, 0, 3'd0, 32'h0);
    check("ands_apsr", {28'h0, apsr}, 32'h0);
    run_op(5'd0, 3'd1, 3'd0, 3'd0, 1'b0, 8'h00, 0, 3'd0, 32'h0);
    run_op(5'd25, 3'd1, 3'd0, 3'd0, 1'b0, 8'h00, 0, 3'd0, 32'h0);
    // Writeback must beat a same-edge external load to rd
    run_op(5'd6, 3'd2, 3'd0, 3'd1, 1'b0, 8'h00, 2, 3'd2, 32'hDEAD_BEEF);
    // A load to an operand register after issue must not disturb the op
    run_op(5'd8, 3'd3, 3'd5, 3'd6, 1'b0, 8'h00, 1, 3'd5, 32'h0BAD_F00D);

    // Randomized commands
    for (int k = 0; k < 40; k++) begin
      logic [4:0] op;
      if ($urandom_range(0, 2) == 0) wr_reg(3'($urandom_range(0, 7)), $urandom);
      if ($urandom_range(0, 7) == 0) op = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom_range(19, 31));
      else op = 5'($urandom_range(1, 18));
      run_op(op, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
             1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), $urandom_range(0, 2),
             3'($urandom_range(0, 7)), $urandom);
    end

    // Back-to-back commands with cmd_valid held high
    wr_reg(3'd0, 32'd5);
    wr_reg(3'd1, 32'd7);
    cmd_valid = 1'b1; cmd_op = 5'd6; cmd_rd = 3'd2; cmd_rn = 3'd0; cmd_rm = 3'd1; cmd_use_imm = 1'b0;
    for (int cyc = 1; cyc <= 9; cyc++) begin
      tick();
      check($sformatf("bb_done_c%0d", cyc), {31'h0, done}, {31'h0, (cyc % 3) == 0});
      check($sformatf("bb_ready_c%0d", cyc), {31'h0, cmd_ready}, {31'h0, (cyc % 3) == 0});
      if (cyc == 9) cmd_valid = 1'b0;
    end
    check("bb_result", done_result, 32'd12);
    m_regs[2] = 32'd12;
    m_apsr = 4'h0;
    check_regs();

    // Reset in ISSUE of the second back-to-back command
    tick();
    cmd_valid = 1'b1; cmd_rd = 3'd3;
    for (int cyc = 1; cyc <= 4; cyc++) tick();
    cmd_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < 8; i++) m_regs[i] = 32'h0;
    m_apsr = 4'h0;
    check("mid_rst_done", {31'h0, done}, 32'h0);
    check("mid_rst_ready", {31'h0, cmd_ready}, 32'h1);
    check("mid_rst_instr", {27'h0, alu_instruction}, 32'h0);
    check("mid_rst_num1", alu_num1, 32'h0);
    check("mid_rst_done_result", done_result, 32'h0);
    rst = 1'b0;
    check_regs();
    for (int cyc = 0; cyc < 4; cyc++) begin
      tick();
      check("post_rst_no_done", {31'h0, done}, 32'h0);
    end
    check_regs();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
